// File: rtl/lamp_sqrt_ctrl_if.sv
// lamp_sqrt_ctrl_if: lampFPU_pkg bfloat16 widths and the operand / core / result handshake bundle.
package lampFPU_pkg;
    localparam int LAMP_FLOAT_DW   = 16;
    localparam int LAMP_FLOAT_E_DW = 8;
    localparam int LAMP_FLOAT_F_DW = 7;
    localparam int LAMP_FLOAT_BIAS = 127;
endpackage

interface lamp_sqrt_ctrl_if;
    logic [lampFPU_pkg::LAMP_FLOAT_DW-1:0]   op_i;
    logic                                    op_valid_i;
    logic                                    op_ready_o;
    logic                                    sqrt_do_o;
    logic [lampFPU_pkg::LAMP_FLOAT_F_DW:0]   sqrt_s_o;
    logic                                    sqrt_is_exp_odd_o;
    logic                                    sqrt_special_o;
    logic [lampFPU_pkg::LAMP_FLOAT_F_DW:0]   sqrt_res_i;
    logic                                    sqrt_valid_i;
    logic [lampFPU_pkg::LAMP_FLOAT_DW-1:0]   res_o;
    logic                                    res_valid_o;
    logic                                    res_ready_i;
    logic                                    invalid_o;
    logic                                    timeout_o;
    modport slave (
        input  op_i, op_valid_i, sqrt_res_i, sqrt_valid_i, res_ready_i,
        output op_ready_o, sqrt_do_o, sqrt_s_o, sqrt_is_exp_odd_o, sqrt_special_o,
               res_o, res_valid_o, invalid_o, timeout_o
    );
    modport master (
        output op_i, op_valid_i, sqrt_res_i, sqrt_valid_i, res_ready_i,
        input  op_ready_o, sqrt_do_o, sqrt_s_o, sqrt_is_exp_odd_o, sqrt_special_o,
               res_o, res_valid_o, invalid_o, timeout_o
    );
endinterface

// File: rtl/lamp_sqrt_ctrl.sv
// lamp_sqrt_ctrl: bfloat16 sqrt sequencer; special cases resolved locally, normals sent to the core.
// Optional watchdog on the core handshake: define LAMP_SQRT_CTRL_TIMEOUT_EN.
module lamp_sqrt_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic              clk,
    input logic              rst,
    lamp_sqrt_ctrl_if.slave  bus
);
    import lampFPU_pkg::*;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                     state, state_nxt;
    logic                       sgn;
    logic [LAMP_FLOAT_E_DW-1:0] e;
    logic [LAMP_FLOAT_F_DW-1:0] f;
    logic                       accept, invalid, special, to_hit;
    logic [LAMP_FLOAT_DW-1:0]   special_res;
    logic [LAMP_FLOAT_E_DW:0]   exp_sum;
    logic [LAMP_FLOAT_F_DW:0]   s_r;
    logic [LAMP_FLOAT_E_DW-1:0] exp_r;
    logic                       odd_r, inv_r, to_r;
    logic [LAMP_FLOAT_DW-1:0]   res_r;
    logic                       unused_bits;

    assign {sgn, e, f}  = bus.op_i;
    assign accept       = bus.op_valid_i && bus.op_ready_o;
    assign invalid      = (e == 8'hFF && f != '0) || (sgn && (e != '0 || f != '0));
    assign special      = invalid || e == 8'hFF || e == '0;
    assign special_res  = invalid ? 16'h7FC0 : e == 8'hFF ? 16'h7F80 : {sgn, 15'b0};
    // (e + bias) / 2 is the biased exponent of the root; the core handles the odd-exponent fold
    assign exp_sum      = {1'b0, e} + 9'(LAMP_FLOAT_BIAS);
    assign unused_bits  = ^{bus.sqrt_res_i[LAMP_FLOAT_F_DW], exp_sum[0]};

`ifdef LAMP_SQRT_CTRL_TIMEOUT_EN
    logic [15:0] cnt;
    assign to_hit = state == WAIT && !bus.sqrt_valid_i && cnt == 16'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else cnt <= accept ? '0 : state == WAIT ? cnt + 16'd1 : cnt;
    end
`else
    logic unused_timeout;
    assign to_hit         = 1'b0;
    assign unused_timeout = TIMEOUT_CYCLES != 0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == IDLE ? (accept ? (special ? DONE : WAIT) : IDLE) :
                    state == WAIT ? ((bus.sqrt_valid_i || to_hit) ? DONE : WAIT) :
                    state == DONE ? (bus.res_ready_i ? IDLE : DONE) : IDLE;
    end

    always_comb begin
        bus.op_ready_o  = rst && state == IDLE;
        bus.sqrt_do_o   = state == WAIT;
        bus.res_valid_o = state == DONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_r   <= '0;
            exp_r <= '0;
            odd_r <= 1'b0;
            res_r <= '0;
            inv_r <= 1'b0;
            to_r  <= 1'b0;
        end else if (accept) begin
            res_r <= special_res;
            inv_r <= invalid;
            to_r  <= 1'b0;
            if (!special) begin
                s_r   <= {1'b1, f};
                odd_r <= ~e[0];
                exp_r <= exp_sum[LAMP_FLOAT_E_DW:1];
            end
        end else if (state == WAIT && bus.sqrt_valid_i) begin
            res_r <= {1'b0, exp_r, bus.sqrt_res_i[LAMP_FLOAT_F_DW-1:0]};
            inv_r <= 1'b0;
            to_r  <= 1'b0;
        end else if (to_hit) begin
            res_r <= 16'h7FC0;
            inv_r <= 1'b0;
            to_r  <= 1'b1;
        end
    end

    assign bus.sqrt_s_o          = s_r;
    assign bus.sqrt_is_exp_odd_o = odd_r;
    assign bus.sqrt_special_o    = 1'b0;
    assign bus.res_o             = res_r;
    assign bus.invalid_o         = inv_r;
    assign bus.timeout_o         = to_r;
endmodule

// File: tb/tb_lamp_sqrt_ctrl.sv
// tb_lamp_sqrt_ctrl: scoreboard bench with a behavioural sqrt core and a bfloat16 sqrt reference model.
module tb_lamp_sqrt_ctrl;
    logic clk_tb = 1'b0;
    logic rst    = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   core_lat = 1;
    bit   core_mute = 1'b0;
    bit   stray_en = 1'b0;
    logic [17:0] exp_q[$];

    lamp_sqrt_ctrl_if bus();
    lamp_sqrt_ctrl #(.TIMEOUT_CYCLES(64)) dut (.clk(clk_tb), .rst(rst), .bus(bus));

    always #5 clk_tb = ~clk_tb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_tb);
        #1;
    endtask

    function automatic int isqrt(input int n);
        int r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    // expected {timeout, invalid, result} from the real-valued meaning of the operand
    function automatic logic [17:0] model(input logic [15:0] op);
        bit s = op[15];
        int e = int'(op[14:7]);
        int f = int'(op[6:0]);
        int ue, m;
        if (e == 255 && f != 0) return {2'b01, 16'h7FC0};
        if (s && (e != 0 || f != 0)) return {2'b01, 16'h7FC0};
        if (e == 255) return {2'b00, 16'h7F80};
        if (e == 0) return {2'b00, s, 15'b0};
        ue = e - 127;
        m  = (ue % 2 == 0) ? isqrt((128 + f) * 128) : isqrt((128 + f) * 256);
        ue = int'($floor(real'(ue) / 2.0));
        return {2'b00, 1'b0, 8'(ue + 127), 7'(m)};
    endfunction

    initial begin
        int cyc = 0;
        bus.sqrt_valid_i = 1'b0;
        bus.sqrt_res_i   = '0;
        forever begin
            @(negedge clk_tb);
            bus.sqrt_valid_i = 1'b0;
            if (bus.sqrt_do_o) begin
                cyc++;
                if (cyc == core_lat && !core_mute) begin
                    bus.sqrt_valid_i = 1'b1;
                    bus.sqrt_res_i = 8'(isqrt(int'(bus.sqrt_s_o) * (bus.sqrt_is_exp_odd_o ? 256 : 128)));
                end
            end else begin
                cyc = 0;
                if (stray_en && $urandom_range(0, 3) == 0) begin
                    bus.sqrt_valid_i = 1'b1;
                    bus.sqrt_res_i   = 8'($urandom);
                end
            end
        end
    end

    always @(negedge clk_tb) begin
        logic [17:0] ev;
        if (rst && bus.res_valid_o && bus.res_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got 0x%0h, required no result", bus.res_o);
            end else begin
                ev = exp_q.pop_front();
                chk("res_o", bus.res_o, ev[15:0]);
                chk("invalid_o", bus.invalid_o, ev[16]);
                chk("timeout_o", bus.timeout_o, ev[17]);
            end
        end
    end

    task automatic issue(input logic [15:0] op);
        int n = 0;
        while (!bus.op_ready_o && n < 200) begin tick(); n++; end
        chk("op_ready_before_issue", bus.op_ready_o, 1);
        bus.op_i = op;
        bus.op_valid_i = 1'b1;
        tick();
        bus.op_valid_i = 1'b0;
        bus.op_i = 16'($urandom);
    endtask

    task automatic run_op(input logic [15:0] op, input int lat, input int hold);
        bit normal = !op[15] && op[14:7] != 8'h00 && op[14:7] != 8'hFF;
        bit stable = 1'b1;
        logic [15:0] first;
        int n = 0;
        core_lat = lat;
        exp_q.push_back(model(op));
        issue(op);
        if (!normal) begin
            chk("special_sqrt_do", bus.sqrt_do_o, 0);
            chk("special_res_valid", bus.res_valid_o, 1);
        end else begin
            chk("sqrt_do", bus.sqrt_do_o, 1);
            chk("sqrt_s", bus.sqrt_s_o, {1'b1, op[6:0]});
            chk("sqrt_is_exp_odd", bus.sqrt_is_exp_odd_o, (int'(op[14:7]) - 127) % 2 != 0);
            chk("sqrt_special", bus.sqrt_special_o, 0);
            while (!bus.res_valid_o && n < lat + 20) begin tick(); n++; end
            chk("normal_latency", n, lat);
            chk("sqrt_do_after_valid", bus.sqrt_do_o, 0);
        end
        first = bus.res_o;
        repeat (hold) begin
            if (bus.res_o !== first || bus.op_ready_o !== 1'b0 || bus.res_valid_o !== 1'b1) stable = 1'b0;
            tick();
        end
        if (hold > 0) chk("backpressure_stable", stable, 1);
        bus.res_ready_i = 1'b1;
        tick();
        bus.res_ready_i = 1'b0;
        chk("op_ready_after_done", bus.op_ready_o, 1);
        chk("res_valid_after_done", bus.res_valid_o, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] op;
        bit bad;
        int n;
        bus.op_i = '0;
        bus.op_valid_i = 1'b0;
        bus.res_ready_i = 1'b0;
        tick(2);
        chk("rst_op_ready", bus.op_ready_o, 0);
        chk("rst_sqrt_do", bus.sqrt_do_o, 0);
        chk("rst_res_valid", bus.res_valid_o, 0);
        chk("rst_res_o", bus.res_o, 0);
        chk("rst_sqrt_s", bus.sqrt_s_o, 0);
        chk("rst_invalid", bus.invalid_o, 0);
        chk("rst_timeout", bus.timeout_o, 0);
        @(negedge clk_tb);
        rst = 1'b1;
        tick();
        chk("op_ready_after_rst", bus.op_ready_o, 1);

        run_op(16'h4080, 10, 0);
        run_op(16'h4000, 3, 2);
        run_op(16'hBF80, 1, 0);
        run_op(16'h7F80, 1, 0);
        run_op(16'h8000, 1, 0);
        run_op(16'h0001, 1, 0);
        run_op(16'h7FC1, 1, 0);
        run_op(16'hFF80, 1, 0);
        run_op(16'h0080, 1, 0);
        run_op(16'h7F7F, 2, 0);
        run_op(16'h3F80, 5, 20);
        run_op(16'hBF80, 1, 20);

        stray_en = 1'b1;
        repeat (60) begin
            op = ($urandom_range(0, 9) < 6) ? {1'b0, 8'($urandom_range(1, 254)), 7'($urandom)} : 16'($urandom);
            run_op(op, $urandom_range(1, 12), $urandom_range(0, 3));
        end
        stray_en = 1'b0;

        core_mute = 1'b1;
        issue(16'h4080);
        tick(3);
        chk("wait_before_rst", bus.sqrt_do_o, 1);
        rst = 1'b0;
        #1;
        chk("rst_drops_sqrt_do", bus.sqrt_do_o, 0);
        chk("rst_drops_op_ready", bus.op_ready_o, 0);
        @(negedge clk_tb);
        rst = 1'b1;
        core_mute = 1'b0;
        stray_en = 1'b1;
        bad = 1'b0;
        repeat (12) begin
            tick();
            if (bus.res_valid_o || bus.sqrt_do_o) bad = 1'b1;
        end
        chk("no_result_after_rst", bad, 0);
        stray_en = 1'b0;

        core_mute = 1'b1;
`ifdef LAMP_SQRT_CTRL_TIMEOUT_EN
        exp_q.push_back({2'b10, 16'h7FC0});
        issue(16'h4080);
        n = 0;
        while (!bus.res_valid_o && n < 100) begin tick(); n++; end
        chk("timeout_latency", n, 64);
        chk("timeout_sqrt_do", bus.sqrt_do_o, 0);
        bus.res_ready_i = 1'b1;
        tick();
        bus.res_ready_i = 1'b0;
`else
        issue(16'h4080);
        tick(100);
        chk("no_timeout_sqrt_do", bus.sqrt_do_o, 1);
        chk("no_timeout_res_valid", bus.res_valid_o, 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
`endif
        core_mute = 1'b0;
        run_op(16'h4000, 4, 0);

        tick(2);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
